lc3_mem_responder: RTL and testbench

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_pkg.sv | 23 ++
 rtl/lc3_rsp_fifo.sv | 57 +++++
 rtl/lc3_mem_responder.sv | 116 +++++++++++
 tb/tb_lc3_mem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared constants, FSM state encoding and response record for the LC-3 memory responder.
package lc3_mem_pkg;

    localparam int ADDR_W         = 8;
    localparam int DATA_W         = 16;
    localparam int DEPTH          = 256;
    localparam int RSP_FIFO_DEPTH = 4;
    localparam int REQ_ADDR_W     = 16;
    localparam int PTR_W          = $clog2(RSP_FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One queued read answer: data plus the full request address it came from.
    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REQ_ADDR_W-1:0] addr;
    } rsp_t;

endpackage

// File: rtl/lc3_rsp_fifo.sv
// Four-entry synchronous response queue; head is visible combinationally, push/pop take effect at the clock edge.
// Push is ignored when full and pop when empty, so the caller's credit scheme is the only overflow guard.
module lc3_rsp_fifo
    import lc3_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  rsp_t             push_dat_i,
    input  logic             pop_i,
    output rsp_t             head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    rsp_t             mem_q [RSP_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(RSP_FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is cleared on reset so the idle head reads back as all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lc3_mem_responder.sv
// 256x16 memory answering fetch/LSU requests; reads respond two cycles after acceptance, in order.
// req_ready is credit based: reads in the read stage plus queued responses never exceed the queue depth.
module lc3_mem_responder
    import lc3_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic                  req_wea,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic [REQ_ADDR_W-1:0] rsp_addr,
    input  logic                  rsp_ready
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_W-1:0]       init_cnt_q;
    logic [ADDR_W-1:0]       init_cnt_d;

    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    rd_vld_q;
    logic [DATA_W-1:0]       rd_data_q;
    logic [REQ_ADDR_W-1:0]   rd_addr_q;

    logic                    wr_acc;
    logic                    rd_acc;
    logic                    rsp_pop;
    logic [CNT_W:0]          credits_used;

    rsp_t                    fifo_head;
    rsp_t                    fifo_push_dat;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    assign wr_acc  = req_valid && req_ready && req_wea;
    assign rd_acc  = req_valid && req_ready && !req_wea;
    assign rsp_pop = rsp_valid && rsp_ready;

    // A read in the read stage already owns a queue slot it will fill next edge.
    assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld_q};

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        req_ready  = 1'b0;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_ready = !fifo_full && (credits_used < (CNT_W + 1)'(RSP_FIFO_DEPTH));
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_vld_q   <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem_q[req_addr[ADDR_W-1:0]];
                rd_addr_q <= req_addr;
            end
        end
    end

    // The upper address byte aliases onto the same 256 words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                mem_q[init_cnt_q] <= '0;
            end else if (wr_acc) begin
                mem_q[req_addr[ADDR_W-1:0]] <= req_wdata;
            end
        end
    end

    assign fifo_push_dat.data = rd_data_q;
    assign fifo_push_dat.addr = rd_addr_q;

    lc3_rsp_fifo u_rsp_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_vld_q),
        .push_dat_i (fifo_push_dat),
        .pop_i      (rsp_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_head.data;
    assign rsp_addr  = fifo_head.addr;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: init sweep timing, latency, aliasing, backpressure, streaming, reset.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic        req_wea = 1'b0;
    logic [15:0] req_wdata = 16'h0000;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        rsp_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wea   (req_wea),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_ready (rsp_ready)
    );

    task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        req_valid = v;
        req_wea   = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Counts negedges until req_ready is seen high, bounded at 400.
    task automatic wait_ready(output int n, output logic spurious);
        n = 0;
        spurious = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (rsp_valid) spurious = 1'b1;
            if (req_ready) break;
        end
    endtask

    task automatic test_reset;
        int   n;
        logic sp;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++;
        if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
        checks++;
        if (rsp_addr !== 16'h0000) begin errors++; $display("FAIL reset_rsp_addr got %h exp 0000", rsp_addr); end
        rst = 1'b0;
        wait_ready(n, sp);
        checks++;
        if (n != 256) begin errors++; $display("FAIL init_sweep_cycles got %0d exp 256", n); end
        checks++;
        if (sp !== 1'b0) begin errors++; $display("FAIL init_rsp_valid got %b exp 0", sp); end
    endtask

    task automatic test_read_cleared;
        drive(1'b1, 1'b0, 16'h00A0, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cleared_early_valid got %b exp 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || rsp_addr !== 16'h00A0) begin
            errors++;
            $display("FAIL cleared_read got v=%b d=%h a=%h exp v=1 d=0000 a=00a0", rsp_valid, rsp_data, rsp_addr);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL cleared_popped got %b exp 0", rsp_valid); end
    endtask

    task automatic test_write_read;
        drive(1'b1, 1'b1, 16'h0005, 16'h1234);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0005, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early_valid got %b exp 0", rsp_valid); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_addr !== 16'h0005) begin
            errors++;
            $display("FAIL wr_rd got v=%b d=%h a=%h exp v=1 d=1234 a=0005", rsp_valid, rsp_data, rsp_addr);
        end
        drive(1'b1, 1'b0, 16'h0105, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_addr !== 16'h0105) begin
            errors++;
            $display("FAIL alias_read got v=%b d=%h a=%h exp v=1 d=1234 a=0105", rsp_valid, rsp_data, rsp_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int   idx;
        int   k;
        int   acc;
        logic stable_bad;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i));
            @(negedge clk);
        end
        idx = 1;
        k = 0;
        acc = 0;
        stable_bad = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            rsp_ready = (cyc >= 8);
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (rsp_data !== 16'hA001 + 16'(k) || rsp_addr !== 16'h0001 + 16'(k)) begin
                    errors++;
                    $display("FAIL bp_order_%0d got d=%h a=%h exp d=%h a=%h", k, rsp_data, rsp_addr,
                             16'hA001 + 16'(k), 16'h0001 + 16'(k));
                end
                k++;
            end else if (rsp_valid && (rsp_data !== 16'hA001 || rsp_addr !== 16'h0001)) begin
                stable_bad = 1'b1;
            end
            if (idx <= 6) drive(1'b1, 1'b0, 16'(idx), 16'h0000);
            else          drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            if (req_valid && req_ready) begin
                idx++;
                if (cyc < 8) acc++;
            end
            if (cyc == 7) begin
                checks++;
                if (acc != 4) begin errors++; $display("FAIL bp_accepts got %0d exp 4", acc); end
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b exp 0", req_ready); end
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (k != 6) begin errors++; $display("FAIL bp_resp_count got %0d exp 6", k); end
        checks++;
        if (stable_bad !== 1'b0) begin errors++; $display("FAIL bp_hold_stable got %b exp 0", stable_bad); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", rsp_valid); end
    endtask

    task automatic test_stream;
        int   k;
        logic ready_bad;
        logic gap_bad;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'h0010 + 16'(i), 16'h5A00 + 16'(i));
            @(negedge clk);
        end
        k = 0;
        ready_bad = 1'b0;
        gap_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid) begin
                checks++;
                if (rsp_data !== 16'h5A00 + 16'(k) || rsp_addr !== 16'h0010 + 16'(k)) begin
                    errors++;
                    $display("FAIL stream_%0d got d=%h a=%h exp d=%h a=%h", k, rsp_data, rsp_addr,
                             16'h5A00 + 16'(k), 16'h0010 + 16'(k));
                end
                if (c != k + 2) gap_bad = 1'b1;
                k++;
            end
            if (c < 8) begin
                drive(1'b1, 1'b0, 16'h0010 + 16'(c), 16'h0000);
                if (!req_ready) ready_bad = 1'b1;
            end else begin
                drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            @(negedge clk);
        end
        checks++;
        if (k != 8) begin errors++; $display("FAIL stream_count got %0d exp 8", k); end
        checks++;
        if (ready_bad !== 1'b0) begin errors++; $display("FAIL stream_ready got stall=%b exp 0", ready_bad); end
        checks++;
        if (gap_bad !== 1'b0) begin errors++; $display("FAIL stream_timing got gap=%b exp 0", gap_bad); end
    endtask

    task automatic test_reset_midflight;
        int   n;
        logic sp;
        logic spurious;
        drive(1'b1, 1'b1, 16'h0007, 16'hBEEF);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0007, 16'h0000);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 16'h0000 || rsp_addr !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b d=%h a=%h exp v=0 r=0 d=0000 a=0000",
                     rsp_valid, req_ready, rsp_data, rsp_addr);
        end
        spurious = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid || req_ready) spurious = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(n, sp);
        checks++;
        if (n != 256) begin errors++; $display("FAIL init_restart_cycles got %0d exp 256", n); end
        checks++;
        if (spurious !== 1'b0 || sp !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_response got %b exp 0", spurious | sp);
        end
        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h0007, 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || rsp_addr !== 16'h0007) begin
            errors++;
            $display("FAIL mid_recleared got v=%b d=%h a=%h exp v=1 d=0000 a=0007", rsp_valid, rsp_data, rsp_addr);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_read_cleared;
        test_write_read;
        test_backpressure;
        test_stream;
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
